// File: rtl/lab7_soc_pio_pkg.sv
// Shared definitions for the lab7 SoC PIO slaves: register word addresses
// and the Avalon readdata width.
package lab7_soc_pio_pkg;

    localparam int unsigned RDATA_W = 32;
    localparam int unsigned ADDR_W  = 2;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_BLINK    = 2'd3;

endpackage

// File: rtl/lab7_soc_blink_tick.sv
// Blink phase generator. The counter runs 0..DIV-1 continuously, and phase
// toggles each time the counter wraps. restart forces a clean start from
// cnt=0, phase=0, and it wins over a wrap on the same edge.
// Ports:
//   clk     - system clock
//   reset   - synchronous active-high reset
//   restart - synchronous counter/phase clear
//   phase   - current blink phase (registered)
module lab7_soc_blink_tick #(
    parameter int unsigned DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic phase
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Phase counter: wraps at DIV-1; reset and restart both clear it.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lab7_soc_out_led.sv
// Avalon-MM LED output port with DATA, OUTSET, OUTCLEAR and BLINK registers.
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset
//   address    - 2-bit word address
//   chipselect - slave select
//   write_n    - active-low write strobe, qualified by chipselect
//   writedata  - write data; only bits [WIDTH-1:0] are used
//   readdata   - registered, zero-extended read data
//   out_port   - LED drive, DATA with blinking bits inverted in phase 1
module lab7_soc_out_led
    import lab7_soc_pio_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [RDATA_W-1:0] writedata,
    output logic [RDATA_W-1:0] readdata,
    output logic [WIDTH-1:0]   out_port
);

    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   blink_q;
    logic [WIDTH-1:0]   wdata_c;
    logic [RDATA_W-1:0] rd_mux_c;
    logic               wr_en_c;
    logic               restart_c;
    logic               phase;
    logic               unused_writedata;

    assign wr_en_c   = chipselect && !write_n;
    assign wdata_c   = writedata[WIDTH-1:0];
    assign restart_c = wr_en_c && (address == ADDR_BLINK);

    // Upper writedata bits are ignored by design.
    assign unused_writedata = ^writedata;

    // Register file write decode. Only one register is written per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            blink_q <= '0;
        end else if (wr_en_c) begin
            case (address)
                ADDR_DATA:     data_q  <= wdata_c;
                ADDR_OUTSET:   data_q  <= data_q | wdata_c;
                ADDR_OUTCLEAR: data_q  <= data_q & ~wdata_c;
                ADDR_BLINK:    blink_q <= wdata_c;
                default:       ;
            endcase
        end
    end

    // Read mux. The write-only set/clear addresses read back as zero.
    always_comb begin
        rd_mux_c = '0;
        case (address)
            ADDR_DATA:  rd_mux_c = RDATA_W'(data_q);
            ADDR_BLINK: rd_mux_c = RDATA_W'(blink_q);
            default:    rd_mux_c = '0;
        endcase
    end

    // readdata is captured every edge, independent of chipselect/write_n,
    // so a same-edge write returns the pre-write value.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux_c;
        end
    end

    lab7_soc_blink_tick #(
        .DIV (BLINK_DIV)
    ) u_blink_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart_c),
        .phase   (phase)
    );

    // Driven from flops only, so there is no input-to-output path.
    assign out_port = data_q ^ (blink_q & {WIDTH{phase}});

endmodule
